// File: rtl/codificador_pkg.sv
// Shared definitions for the request encoder.
//   N     : number of request lines
//   W     : width of the encoded index (log2 N)
//   state_t : FSM encoding, IDLE (nothing offered) / OFFER (code on S)
package codificador_pkg;

   localparam int N = 8;
   localparam int W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

endpackage

// File: rtl/codificador_fila_prio_enc8.sv
// prio_enc8: combinational highest-index-first priority encoder.
//   v      in  N  candidate vector
//   code   out W  index of the highest set bit (0 when v == 0)
//   hit    out 1  v has at least one bit set
//   onehot out N  the selected bit alone, used by the caller to clear it
module prio_enc8
   import codificador_pkg::*;
(
   input  logic [N-1:0] v,
   output logic [W-1:0] code,
   output logic         hit,
   output logic [N-1:0] onehot
);

   // Ascending scan: the last set bit seen is the highest one.
   always_comb begin
      code   = '0;
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            code      = W'(i);
            onehot    = '0;
            onehot[i] = 1'b1;
         end
      end
      hit = |v;
   end

endmodule

// File: rtl/codificador_fila.sv
// codificador_fila: latches up to N request lines into a pending register and
// offers them one at a time as a binary index, highest index first.
//   clk     in  1  clock, rising edge
//   rst     in  1  asynchronous active-high reset
//   E       in  1  enable for new requests (pending ones are still served)
//   A       in  N  request lines, level-sampled every cycle
//   S       out W  offered index (registered)
//   valid   out 1  S holds a request (registered)
//   ready   in  1  consumer accepts S this cycle
//   vazio   out 1  nothing pending and nothing offered (registered)
//   colisao out 1  sticky: a request hit a bit that was already pending
//   estado  out 1  current FSM state, for observation
//
// Handshake: a transfer happens on every rising edge where valid && ready.
// While valid && !ready, S is held. ready while valid == 0 has no effect.
module codificador_fila
   import codificador_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         E,
   input  logic [N-1:0] A,
   output logic [W-1:0] S,
   output logic         valid,
   input  logic         ready,
   output logic         vazio,
   output logic         colisao,
   output state_t       estado
);

   logic [N-1:0] p;
   logic [N-1:0] r;
   logic [N-1:0] m;
   logic [W-1:0] code;
   logic         hit;
   logic [N-1:0] onehot;
   logic         load;
   logic         drop;
   logic [N-1:0] p_next;
   logic [N-1:0] lost;
   logic         valid_next;

   assign r = A & {N{E}};
   assign m = p | r;

   prio_enc8 u_enc (
      .v      (m),
      .code   (code),
      .hit    (hit),
      .onehot (onehot)
   );

   // A new index is loaded from IDLE, or from OFFER when the current one
   // transfers; otherwise the offer is held.
   assign load = hit && ((estado == IDLE) || ready);
   assign drop = (estado == OFFER) && ready && !hit;

   // The selected bit leaves P, unless it was already pending and requested
   // again on the same edge: the fresh request wins and the bit stays.
   always_comb begin
      p_next     = m;
      lost       = p & r;
      valid_next = valid;
      if (load) begin
         p_next     = (m & ~onehot) | (p & r & onehot);
         lost       = p & r & ~onehot;
         valid_next = 1'b1;
      end else if (drop) begin
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado  <= IDLE;
         p       <= '0;
         S       <= '0;
         valid   <= 1'b0;
         colisao <= 1'b0;
         vazio   <= 1'b1;
      end else begin
         p     <= p_next;
         valid <= valid_next;
         vazio <= (p_next == '0) && !valid_next;
         if (|lost)
            colisao <= 1'b1;
         if (load)
            S <= code;
         case (estado)
            IDLE:    if (load) estado <= OFFER;
            OFFER:   if (drop) estado <= IDLE;
            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_codificador_fila.sv
// Directed bench for codificador_fila: inputs change 1 time unit after the
// rising edge, outputs are checked at that same point (well away from edges).
module tb_codificador_fila;
   import codificador_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         E;
   logic [N-1:0] A;
   logic [W-1:0] S;
   logic         valid;
   logic         ready;
   logic         vazio;
   logic         colisao;
   state_t       estado;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   codificador_fila dut (
      .clk     (clk),
      .rst     (rst),
      .E       (E),
      .A       (A),
      .S       (S),
      .valid   (valid),
      .ready   (ready),
      .vazio   (vazio),
      .colisao (colisao),
      .estado  (estado)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // valid, S, vazio, colisao in one call
   task automatic chk_all(input string tag, input logic v, input logic [W-1:0] s,
                          input logic vz, input logic c);
      chk({tag, ".valid"},   8'(v),  8'(valid));
      if (v) chk({tag, ".S"}, 8'(S), 8'(s));
      chk({tag, ".vazio"},   8'(vazio),   8'(vz));
      chk({tag, ".colisao"}, 8'(colisao), 8'(c));
   endtask

   initial begin
      rst = 1'b1; E = 1'b1; A = '0; ready = 1'b0;
      #12;
      chk("rst.S", 8'(S), 8'h00);
      chk_all("rst", 1'b0, 3'd0, 1'b1, 1'b0);
      chk("rst.estado", 8'(estado), 8'(IDLE));
      rst = 1'b0;
      tick();

      // single request, stalled consumer
      A = 8'b0010_0000; ready = 1'b0;
      tick();
      A = '0;
      chk_all("single.first", 1'b1, 3'd5, 1'b0, 1'b0);
      chk("single.estado", 8'(estado), 8'(OFFER));
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_all("single.stall", 1'b1, 3'd5, 1'b0, 1'b0);
      end
      ready = 1'b1;
      tick();
      chk_all("single.done", 1'b0, 3'd0, 1'b1, 1'b0);

      // multi-request drain, highest first
      A = 8'b1000_0101; ready = 1'b1;
      tick();
      A = '0;
      chk_all("drain.7", 1'b1, 3'd7, 1'b0, 1'b0);
      tick();
      chk_all("drain.2", 1'b1, 3'd2, 1'b0, 1'b0);
      tick();
      chk_all("drain.0", 1'b1, 3'd0, 1'b0, 1'b0);
      tick();
      chk_all("drain.end", 1'b0, 3'd0, 1'b1, 1'b0);

      // enable gate
      E = 1'b0; A = 8'hFF; ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all("gate.off", 1'b0, 3'd0, 1'b1, 1'b0);
      end
      E = 1'b1; A = 8'h03;
      tick();
      chk_all("gate.load", 1'b1, 3'd1, 1'b0, 1'b0);
      E = 1'b0; A = 8'hFF;
      tick();
      chk_all("gate.hold", 1'b1, 3'd1, 1'b0, 1'b0);
      ready = 1'b1;
      tick();
      chk_all("gate.pend0", 1'b1, 3'd0, 1'b0, 1'b0);
      tick();
      chk_all("gate.empty", 1'b0, 3'd0, 1'b1, 1'b0);
      E = 1'b1; A = '0; ready = 1'b0;

      // reset mid-offer with P = 8'h0F
      A = 8'h1F;
      tick();
      A = '0;
      chk_all("pre_rst", 1'b1, 3'd4, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst.S", 8'(S), 8'h00);
      chk_all("midrst", 1'b0, 3'd0, 1'b1, 1'b0);
      tick();
      rst = 1'b0; ready = 1'b1;
      tick();
      chk_all("postrst.P_clear", 1'b0, 3'd0, 1'b1, 1'b0);

      // collisions
      A = 8'h03; ready = 1'b0;
      tick();
      chk_all("col.load", 1'b1, 3'd1, 1'b0, 1'b0);
      A = 8'h01;
      tick();
      chk_all("col.hit", 1'b1, 3'd1, 1'b0, 1'b1);
      A = 8'h02; ready = 1'b1;
      tick();
      A = '0;
      chk_all("col.reoffer1", 1'b1, 3'd1, 1'b0, 1'b1);
      tick();
      chk_all("col.then0", 1'b1, 3'd0, 1'b0, 1'b1);
      tick();
      chk_all("col.empty", 1'b0, 3'd0, 1'b1, 1'b1);

      rst = 1'b1;
      #1;
      chk("col.cleared", 8'(colisao), 8'h00);
      tick();
      rst = 1'b0;

      // back-to-back streaming
      A = 8'h80; ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_all("stream", 1'b1, 3'd7, 1'b0, 1'b0);
      end
      A = '0;
      tick();
      chk_all("stream.end", 1'b0, 3'd0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/codificador_fila.md
# codificador_fila

Request encoder with a pending queue: the inverse of the 3-to-8 one-hot decoder. Eight request lines are latched into a pending register and served one at a time as a 3-bit binary code over a valid/ready handshake, highest index first. It sits between event sources such as interrupts, flags or one-hot strobes and a consumer that accepts one encoded index per transfer.

## Interface
- N, 8, number of request lines (fixed at 8 for this revision).
- W, 3, code width, equal to log2(N).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- E  in  1  enable. When 0, new requests on A are ignored; requests already pending are still served.
- A  in  N  request lines, sampled every cycle. Level-sampled: a line held high re-requests every cycle.
- S  out  W  encoded index of the request being offered. Registered.
- valid  out  1  S holds a request. Registered.
- ready  in  1  consumer accepts S this cycle.
- vazio  out  1  high when nothing is pending and valid = 0. Registered.
- colisao  out  1  sticky lost-request flag. Registered.

## Operation
- State per line: pending register P[N-1:0], one bit per line.
- New requests this cycle: R = A & {N{E}}.
- Merged vector: M = P | R, minus the bit served this cycle (see FSM).
- Priority: the highest set index wins. Bit 7 gives S = 3'b111; bit 0 gives S = 3'b000. The encoding is the exact inverse of the decoder mapping (S = k for bit k).
- FSM, 2 states:
  - IDLE: valid = 0. If M ≠ 0:
    - load S = the top index of M;
    - clear that bit from P;
    - set valid = 1;
    - go to OFFER.
  - OFFER: valid = 1 and S is held stable while ready = 0.
    - On ready = 1 with M ≠ 0 (M taken after the current transfer): load the next index the same edge (back-to-back) and stay in OFFER.
    - On ready = 1 with M = 0: valid ← 0, go to IDLE.
- Collision:
  - A request on a bit already set in P, and not being served this edge, is lost.
  - colisao ← 1 and stays 1 until rst.
  - A request on the bit being served/cleared this same edge is not a collision. The new request wins, so the bit remains pending.
- A request on the bit currently offered in S, while in OFFER, lands in P normally. It is served again later and is not a collision.
- vazio = (P_next == 0) && !valid_next.

## Timing
- Reset values: S = 0, valid = 0, colisao = 0, vazio = 1, P = 0, state IDLE. rst takes effect immediately, mid-transfer included. A pending offer is dropped without handshake.
- Latency: a request sampled at edge k in IDLE produces valid = 1 with its code after edge k (1 cycle).
- Throughput: one code per cycle while ready is held high and M stays non-zero.
- Handshake rules:
  - transfer occurs on an edge where valid && ready;
  - S must not change while valid && !ready;
  - ready while valid = 0 is ignored.
- Same-edge collision rules: set/clear on the same bit resolves as set. Simultaneous requests on several lines are all latched; none is lost unless already pending.

## Structure
- Shared package codificador_pkg holds:
  - N and W constants;
  - state encoding: IDLE = 1'b0, OFFER = 1'b1.
- Sub-module prio_enc8 is combinational:
  - input: vector v[7:0];
  - outputs: code[2:0], hit (v ≠ 0), onehot[7:0] (the selected bit, used to clear P).
- Top level contains P, the FSM, and the S/valid/colisao/vazio registers.

## Test plan
- Reset mid-offer:
  - stimulus: rst pulse with valid = 1 and P = 8'h0F;
  - response: the same cycle, valid = 0, S = 0, colisao = 0, vazio = 1.
- Single request with stalled consumer:
  - stimulus: E = 1, A = 8'b0010_0000 for one cycle, ready = 0;
  - response: next cycle valid = 1, S = 3'b101;
  - S is held 5 cycles while stalled;
  - ready = 1 → valid = 0 next cycle, vazio = 1.
- Multi-request drain:
  - stimulus: A = 8'b1000_0101 for one cycle, ready = 1;
  - response: S = 7, 2, 0 on three consecutive cycles, then valid = 0.
- Enable gate:
  - stimulus: E = 0, A = 8'hFF;
  - response: valid stays 0 and vazio = 1;
  - pending bits are still drained when E is toggled later.
- Collision cases:
  - stimulus: A = 8'h02 and 8'h01 in one cycle with ready = 0, then A = 8'h01 again;
  - response: colisao = 1 (bit 0 was still pending);
  - re-requesting bit 1 on the edge it transfers → no collision, and S = 1 is offered again.
- Back-to-back streaming:
  - stimulus: ready held at 1, A = 8'h80 every cycle;
  - response: valid is continuously 1, S = 7 every cycle, colisao stays 0.
